csr_irq_unit: RTL and testbench
===============================

// Module: csr_irq_unit
// PURPOSE
//  Machine-mode CSR file plus interrupt controller for the RV32 core; next generation of the single-source CSR block.
//  Adds NUM_IRQ external lines with per-line enable and lowest-index priority, plus mcause/mtvec/mscratch and writable 64-bit counters.
//  Sits beside the EX stage; the core flushes on trap_take and redirects fetch to trap_pc (trap) or ret_pc (mret).
// PARAMETERS
//  NUM_IRQ      8             external interrupt lines, 1..31
//  MTVEC_RESET  32'h0001_0000 reset value of mtvec (ISR base)
//  CNT_W        64            mcycle/minstret width, 33..64; upper halves read zero-extended
// PORTS
//  clk          in   1        clock
//  rst          in   1        asynchronous reset, active-low
//  csr_wr       in   1        CSR instruction valid in EX
//  csr_op       in   3        funct3: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI
//  csr_addr     in   12       CSR address
//  csr_wdata    in   32       operand: rs1 data, or zero-extended uimm; the core selects
//  mret         in   1        mret valid in EX
//  wfi          in   1        wfi valid in EX
//  stall        in   1        pipeline stall (im_stall|dm_stall); freezes all updates except mcycle
//  pc           in   32       PC of the EX instruction
//  retire       in   1        instruction retires this cycle
//  irq          in   NUM_IRQ  level-sensitive external requests (e.g. DMA done)
//  timer_irq    in   1        level-sensitive WDT/timer request
//  csr_rdata    out  32       combinational read of csr_addr; unimplemented reads 0
//  trap_take    out  1        combinational; interrupt taken this cycle
//  trap_pc      out  32       handler address, valid with trap_take
//  ret_pc       out  32       mepc
//  wfi_stall    out  1        registered; holds the core while waiting
// BEHAVIOUR
//  - Reset: mstatus=0, mie=0, irq_en=all 1, mepc=0, mcause=0, mscratch=0, mtvec=MTVEC_RESET, counters=0, wfi_stall=0.
//  - mip (0x344, read-only): MEIP[11]=|(irq&irq_en); MTIP[7]=timer_irq. irq_en at 0xBC0, low NUM_IRQ bits. irq_id (0xFC0, read-only) = index of lowest pending enabled line, 0 if none.
//  - mie writable bits 7, 11 only; mstatus writable MIE[3], MPIE[7], MPP[12:11] only; other bits read 0.
//  - Take: trap_take = mstatus.MIE & ~stall & ((mie[11]&MEIP) | (mie[7]&MTIP)). External beats timer.
//  - Next edge after take: mepc<=pc; mcause<={1'b1, 27'd0, 11 or 7}; MPIE<=MIE; MIE<=0; MPP<=2'b11; wfi_stall<=0.
//    The same-cycle CSR write / mret / wfi is discarded (instruction flushed).
//  - trap_pc = {mtvec[31:2], 2'b00} (direct mode).
//  - mret (~stall, no take): MIE<=MPIE, MPIE<=1, MPP<=11; ret_pc=mepc.
//  - CSR write (~stall, no take): RW/RWI always write; RS/RC(I) with csr_wdata==0 write nothing. mepc/mtvec bit0 and mepc bit1 forced 0.
//  - Writes land at the next edge; csr_rdata shows the old value in the write cycle.
//  - Counters: mcycle +1 every cycle; minstret +1 on retire&~stall. A CSR write to a counter half wins over the increment that cycle.
//    Write addresses 0xB00/0xB80/0xB02/0xB82 (read-only aliases 0xC00/0xC80/0xC02/0xC82). Wrap at 2^CNT_W-1 -> 0.
//  - WFI: wfi&~stall sets wfi_stall. It clears when any (mip&mie) bit is set, regardless of mstatus.MIE; the pending interrupt is then taken if MIE=1.
//  - Reset mid-WFI or mid-trap: all state returns to reset values immediately (async).
// CONFIGURATION
//  CSR_VECTORED_EN defined: mtvec[1:0]=01 selects vectored mode, trap_pc = {mtvec[31:2],2'b00} + 4*cause.
//    External traps vector instead to base + 4*(16+irq_id), and mcause code = 16+irq_id.
//  CSR_VECTORED_EN undefined: mtvec[1:0] hardwired 00, direct mode only, external mcause code always 11.
// STRUCTURE
//  csr_pkg: CSR address localparams, csr_op_e enum, bit positions (MIE, MPIE, MPP, MTIP, MEIP), mcause code constants.
//  Sub-module csr_irq_arbiter: NUM_IRQ-wide masked lowest-index priority encoder -> {any, id}.
// TESTING
//  - Reset, read 0x305 -> 0x0001_0000; read 0x300, 0x304, 0x344 -> 0. Run 10 cycles, read 0xB00 -> 10 (+/- read skew).
//  - CSRRS 0x300 wdata 8, CSRRS 0x304 wdata 0x800, pc=0x100, irq=0x24 -> trap_take=1; next cycle mcause=0x8000000B, mepc=0x100, irq_id=2, mstatus=0x1880.
//  - MIE=1, mie=0x880, irq and timer_irq rise in the same cycle -> external trap taken, mcause code 11.
//    After mret, with the external request still pending, timer_irq still high -> external taken again; drop irq -> timer trap taken, mcause 0x80000007.
//  - wfi with MIE=0, mie[11]=1 -> wfi_stall=1 until irq[0]=1, then wfi_stall=0 next cycle, no trap_take.
//  - CSRRW 0xB00 with 0xFFFF_FFFF then CSRRW 0xB80 with 0xFFFF_FFFF -> mcycle wraps to 0 then increments; assert stall during a CSRRW -> no write.
//  - CSR_VECTORED_EN: mtvec=0x0001_0001, irq[3] -> trap_pc = 0x0001_0000 + 4*19 = 0x0001_004C, mcause=0x80000013.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR / interrupt unit: CSR
// addresses, the funct3 operation encoding, mstatus/mip bit positions,
// mcause codes and the read-modify-write helpers used by the CSR file.
package csr_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned CAUSE_W = 6;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_IRQ_EN    = 12'hBC0;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
  localparam logic [11:0] CSR_IRQ_ID    = 12'hFC0;

  typedef enum logic [2:0] {
    CSR_OP_RW  = 3'b001,
    CSR_OP_RS  = 3'b010,
    CSR_OP_RC  = 3'b011,
    CSR_OP_RWI = 3'b101,
    CSR_OP_RSI = 3'b110,
    CSR_OP_RCI = 3'b111
  } csr_op_e;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_WFI = 1'b1
  } wfi_state_e;

  localparam int unsigned MSTATUS_MIE    = 3;
  localparam int unsigned MSTATUS_MPIE   = 7;
  localparam int unsigned MSTATUS_MPP_LO = 11;
  localparam int unsigned MSTATUS_MPP_HI = 12;
  localparam int unsigned MIP_MTIP       = 7;
  localparam int unsigned MIP_MEIP       = 11;

  localparam logic [XLEN-1:0] MSTATUS_WMASK = 32'h0000_1888;
  localparam logic [XLEN-1:0] MIE_WMASK     = 32'h0000_0880;

  localparam logic [CAUSE_W-1:0] CAUSE_MTI      = 6'd7;
  localparam logic [CAUSE_W-1:0] CAUSE_MEI      = 6'd11;
  localparam logic [CAUSE_W-1:0] CAUSE_EXT_BASE = 6'd16;

  // Set/clear forms with a zero operand are reads only.
  function automatic logic csr_op_writes(csr_op_e op, logic [XLEN-1:0] wdata);
    case (op)
      CSR_OP_RW, CSR_OP_RWI: return 1'b1;
      CSR_OP_RS, CSR_OP_RSI,
      CSR_OP_RC, CSR_OP_RCI: return (wdata != '0);
      default:               return 1'b0;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] csr_apply(csr_op_e op, logic [XLEN-1:0] old,
                                                logic [XLEN-1:0] wdata);
    case (op)
      CSR_OP_RW, CSR_OP_RWI: return wdata;
      CSR_OP_RS, CSR_OP_RSI: return old | wdata;
      CSR_OP_RC, CSR_OP_RCI: return old & ~wdata;
      default:               return old;
    endcase
  endfunction

  // Per-line cause code used when external traps are vectored.
  function automatic logic [CAUSE_W-1:0] ext_vec_cause(logic [4:0] id);
    return CAUSE_EXT_BASE + CAUSE_W'(id);
  endfunction

endpackage

// File: rtl/csr_irq_unit_if.sv
// Core <-> CSR/interrupt unit bundle.
// master: core side (drives CSR access, mret/wfi, stall, pc, retire, irq lines)
// slave : csr_irq_unit (returns csr_rdata, trap_take, trap_pc, ret_pc, wfi_stall)
interface csr_irq_unit_if #(
  parameter int unsigned NUM_IRQ = 8
);
  import csr_pkg::*;

  logic               csr_wr;
  logic [2:0]         csr_op;
  logic [11:0]        csr_addr;
  logic [XLEN-1:0]    csr_wdata;
  logic               mret;
  logic               wfi;
  logic               stall;
  logic [XLEN-1:0]    pc;
  logic               retire;
  logic [NUM_IRQ-1:0] irq;
  logic               timer_irq;
  logic [XLEN-1:0]    csr_rdata;
  logic               trap_take;
  logic [XLEN-1:0]    trap_pc;
  logic [XLEN-1:0]    ret_pc;
  logic               wfi_stall;

  modport master (
    output csr_wr, csr_op, csr_addr, csr_wdata, mret, wfi, stall, pc, retire,
           irq, timer_irq,
    input  csr_rdata, trap_take, trap_pc, ret_pc, wfi_stall
  );

  modport slave (
    input  csr_wr, csr_op, csr_addr, csr_wdata, mret, wfi, stall, pc, retire,
           irq, timer_irq,
    output csr_rdata, trap_take, trap_pc, ret_pc, wfi_stall
  );
endinterface

// File: rtl/csr_irq_arbiter.sv
// Masked lowest-index priority encoder over the external interrupt lines.
// req_i : pending & enabled lines
// any_o : some line requesting (combinational)
// id_o  : index of the lowest requesting line, 0 when none (combinational)
module csr_irq_arbiter #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] req_i,
  output logic         any_o,
  output logic [4:0]   id_o
);

  // Scan high to low so the lowest set index is the last assignment.
  always_comb begin
    any_o = |req_i;
    id_o  = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req_i[i]) id_o = 5'(i);
    end
  end

endmodule

// File: rtl/csr_irq_unit.sv
// Machine-mode CSR file + interrupt controller beside the EX stage.
// Ports: clk, rst (async, active-low), bus (csr_irq_unit_if.slave):
//   CSR access (csr_wr/op/addr/wdata -> csr_rdata), mret/wfi/stall/pc/retire,
//   irq[NUM_IRQ]/timer_irq in; trap_take/trap_pc/ret_pc (combinational) and
//   wfi_stall (registered) out.
// Build option: define CSR_VECTORED_EN to allow mtvec[1:0]=01 vectored mode.
module csr_irq_unit
  import csr_pkg::*;
#(
  parameter int unsigned     NUM_IRQ     = 8,
  parameter logic [XLEN-1:0] MTVEC_RESET = 32'h0001_0000,
  parameter int unsigned     CNT_W       = 64
) (
  input logic           clk,
  input logic           rst,
  csr_irq_unit_if.slave bus
);

  localparam int unsigned HI_W = CNT_W - 32;
`ifdef CSR_VECTORED_EN
  localparam logic [XLEN-1:0] MTVEC_WMASK = 32'hFFFF_FFFD;
`else
  localparam logic [XLEN-1:0] MTVEC_WMASK = 32'hFFFF_FFFC;
`endif

  logic [XLEN-1:0]    mstatus_q, mstatus_d, mie_q, mie_d, mtvec_q, mtvec_d;
  logic [XLEN-1:0]    mscratch_q, mscratch_d, mepc_q, mepc_d, mcause_q, mcause_d;
  logic [NUM_IRQ-1:0] irq_en_q, irq_en_d;
  logic [CNT_W-1:0]   mcycle_q, mcycle_d, minstret_q, minstret_d;
  wfi_state_e         state_q, state_d;

  logic [NUM_IRQ-1:0] irq_pend;
  logic               ext_any;
  logic [4:0]         ext_id;
  logic [XLEN-1:0]    mip, int_pend, rdata, wval, trap_base, trap_pc;
  logic               take_ext, take_tim, trap_take, csr_we, mret_en, wfi_en;
  logic [CAUSE_W-1:0] cause_code;
  csr_op_e            op;

  assign irq_pend = bus.irq & irq_en_q;

  csr_irq_arbiter #(.N(NUM_IRQ)) u_arb (
    .req_i (irq_pend),
    .any_o (ext_any),
    .id_o  (ext_id)
  );

  always_comb begin
    mip           = '0;
    mip[MIP_MEIP] = ext_any;
    mip[MIP_MTIP] = bus.timer_irq;
  end

  // Trap decision; external outranks timer when both are enabled.
  assign int_pend  = mip & mie_q;
  assign take_ext  = int_pend[MIP_MEIP];
  assign take_tim  = int_pend[MIP_MTIP];
  assign trap_take = mstatus_q[MSTATUS_MIE] & ~bus.stall & (take_ext | take_tim);
  assign trap_base = {mtvec_q[XLEN-1:2], 2'b00};

`ifdef CSR_VECTORED_EN
  logic vec_mode;
  assign vec_mode   = (mtvec_q[1:0] == 2'b01);
  assign cause_code = take_ext ? (vec_mode ? ext_vec_cause(ext_id) : CAUSE_MEI) : CAUSE_MTI;
  assign trap_pc    = vec_mode ? trap_base + {24'd0, cause_code, 2'b00} : trap_base;
`else
  assign cause_code = take_ext ? CAUSE_MEI : CAUSE_MTI;
  assign trap_pc    = trap_base;
`endif

  // CSR read mux; unimplemented addresses read zero.
  always_comb begin
    rdata = '0;
    case (bus.csr_addr)
      CSR_MSTATUS:               rdata = mstatus_q;
      CSR_MIE:                   rdata = mie_q;
      CSR_MTVEC:                 rdata = mtvec_q;
      CSR_MSCRATCH:              rdata = mscratch_q;
      CSR_MEPC:                  rdata = mepc_q;
      CSR_MCAUSE:                rdata = mcause_q;
      CSR_MIP:                   rdata = mip;
      CSR_IRQ_EN:                rdata = XLEN'(irq_en_q);
      CSR_IRQ_ID:                rdata = XLEN'(ext_id);
      CSR_MCYCLE, CSR_CYCLE:     rdata = mcycle_q[31:0];
      CSR_MCYCLEH, CSR_CYCLEH:   rdata = XLEN'(mcycle_q[CNT_W-1:32]);
      CSR_MINSTRET, CSR_INSTRET: rdata = minstret_q[31:0];
      CSR_MINSTRETH, CSR_INSTRETH: rdata = XLEN'(minstret_q[CNT_W-1:32]);
      default:                   rdata = '0;
    endcase
  end

  // A taken trap flushes the EX instruction, so its write/mret/wfi is dropped.
  assign op      = csr_op_e'(bus.csr_op);
  assign csr_we  = bus.csr_wr & ~bus.stall & ~trap_take & csr_op_writes(op, bus.csr_wdata);
  assign wval    = csr_apply(op, rdata, bus.csr_wdata);
  assign mret_en = bus.mret & ~bus.stall & ~trap_take;
  assign wfi_en  = bus.wfi & ~bus.stall & ~trap_take;

  // Next-state for all CSR state and the WFI state machine.
  always_comb begin
    mstatus_d  = mstatus_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    irq_en_d   = irq_en_q;
    mcycle_d   = mcycle_q + CNT_W'(1);
    minstret_d = minstret_q + CNT_W'(bus.retire & ~bus.stall);
    state_d    = state_q;

    if (csr_we) begin
      case (bus.csr_addr)
        CSR_MSTATUS:   mstatus_d  = wval & MSTATUS_WMASK;
        CSR_MIE:       mie_d      = wval & MIE_WMASK;
        CSR_MTVEC:     mtvec_d    = wval & MTVEC_WMASK;
        CSR_MSCRATCH:  mscratch_d = wval;
        CSR_MEPC:      mepc_d     = wval & 32'hFFFF_FFFC;
        CSR_MCAUSE:    mcause_d   = wval;
        CSR_IRQ_EN:    irq_en_d   = wval[NUM_IRQ-1:0];
        // Writing either half suppresses that cycle's increment entirely.
        CSR_MCYCLE:    mcycle_d   = {mcycle_q[CNT_W-1:32], wval};
        CSR_MCYCLEH:   mcycle_d   = {HI_W'(wval), mcycle_q[31:0]};
        CSR_MINSTRET:  minstret_d = {minstret_q[CNT_W-1:32], wval};
        CSR_MINSTRETH: minstret_d = {HI_W'(wval), minstret_q[31:0]};
        default: ;
      endcase
    end

    if (mret_en) begin
      mstatus_d[MSTATUS_MIE]                   = mstatus_q[MSTATUS_MPIE];
      mstatus_d[MSTATUS_MPIE]                  = 1'b1;
      mstatus_d[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    end

    if (trap_take) begin
      mepc_d                                   = bus.pc;
      mcause_d                                 = {1'b1, 25'd0, cause_code};
      mstatus_d[MSTATUS_MPIE]                  = mstatus_q[MSTATUS_MIE];
      mstatus_d[MSTATUS_MIE]                   = 1'b0;
      mstatus_d[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    end

    // Wake on any enabled pending interrupt, independent of mstatus.MIE.
    case (state_q)
      ST_RUN:  if (wfi_en) state_d = ST_WFI;
      ST_WFI:  if (|int_pend) state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mstatus_q  <= '0;
      mie_q      <= '0;
      mtvec_q    <= MTVEC_RESET & MTVEC_WMASK;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      irq_en_q   <= '1;
      mcycle_q   <= '0;
      minstret_q <= '0;
      state_q    <= ST_RUN;
    end else begin
      mstatus_q  <= mstatus_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      irq_en_q   <= irq_en_d;
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
      state_q    <= state_d;
    end
  end

  assign bus.csr_rdata = rdata;
  assign bus.trap_take = trap_take;
  assign bus.trap_pc   = trap_pc;
  assign bus.ret_pc    = mepc_q;
  assign bus.wfi_stall = (state_q == ST_WFI);

endmodule

// File: tb/tb_csr_irq_unit.sv
// Self-checking bench for csr_irq_unit: expectations are queued as stimulus
// is applied and compared against the collected DUT observations per test.
module tb_csr_irq_unit;

  logic clk, rst;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] got[$];

  csr_irq_unit_if #(.NUM_IRQ(8)) bus ();

  csr_irq_unit #(
    .NUM_IRQ     (8),
    .MTVEC_RESET (32'h0001_0000),
    .CNT_W       (64)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

`ifdef CSR_VECTORED_EN
  localparam logic [31:0] MTVEC_WR_EXP = 32'h0002_0001;
`else
  localparam logic [31:0] MTVEC_WR_EXP = 32'h0002_0000;
`endif

  localparam logic [2:0] OP_RW = 3'b001;
  localparam logic [2:0] OP_RS = 3'b010;
  localparam logic [2:0] OP_RC = 3'b011;

  task automatic idle();
    bus.csr_wr = 1'b0; bus.csr_op = 3'b000; bus.csr_wdata = '0;
    bus.mret = 1'b0; bus.wfi = 1'b0; bus.stall = 1'b0; bus.retire = 1'b0;
  endtask

  // One-cycle CSR instruction, returns at the following negedge.
  task automatic csr(input logic [2:0] op, input logic [11:0] a, input logic [31:0] d);
    bus.csr_wr = 1'b1; bus.csr_op = op; bus.csr_addr = a; bus.csr_wdata = d;
    @(negedge clk);
    bus.csr_wr = 1'b0;
  endtask

  task automatic expect_rd(input string n, input logic [11:0] a, input logic [31:0] v);
    sb.push_back('{name: n, val: v});
    bus.csr_addr = a;
    #1;
    got.push_back(bus.csr_rdata);
  endtask

  task automatic expect_sig(input string n, input logic [31:0] act, input logic [31:0] v);
    sb.push_back('{name: n, val: v});
    got.push_back(act);
  endtask

  task automatic test_reset();
    exp_t e; logic [31:0] o;
    rst = 1'b0; idle();
    bus.csr_addr = '0; bus.pc = '0; bus.irq = '0; bus.timer_irq = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    expect_rd("mtvec_rst", 12'h305, 32'h0001_0000);
    expect_rd("mstatus_rst", 12'h300, 32'h0);
    expect_rd("mie_rst", 12'h304, 32'h0);
    expect_rd("mip_rst", 12'h344, 32'h0);
    expect_rd("irq_en_rst", 12'hBC0, 32'h0000_00FF);
    expect_rd("mcycle_rst", 12'hB00, 32'h0);
    expect_sig("wfi_stall_rst", {31'd0, bus.wfi_stall}, 32'h0);
    repeat (10) @(negedge clk);
    expect_rd("mcycle_10", 12'hB00, 32'd10);
    expect_rd("mcycleh_10", 12'hB80, 32'd0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = got.pop_front(); checks++;
      if (o !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, o, e.val); end
    end
  endtask

  task automatic test_trap();
    exp_t e; logic [31:0] o;
    csr(OP_RS, 12'h300, 32'h8);
    csr(OP_RS, 12'h304, 32'h800);
    bus.pc = 32'h100; bus.irq = 8'h24;
    // CSR write in the take cycle must be flushed
    bus.csr_wr = 1'b1; bus.csr_op = OP_RW; bus.csr_addr = 12'h340; bus.csr_wdata = 32'hDEAD;
    #1;
    expect_sig("take_ext", {31'd0, bus.trap_take}, 32'h1);
    expect_sig("trap_pc_direct", bus.trap_pc, 32'h0001_0000);
    @(negedge clk);
    bus.csr_wr = 1'b0;
    expect_rd("mcause_ext", 12'h342, 32'h8000_000B);
    expect_rd("mepc_trap", 12'h341, 32'h100);
    expect_rd("irq_id", 12'hFC0, 32'd2);
    expect_rd("mstatus_trap", 12'h300, 32'h0000_1880);
    expect_rd("mscratch_flushed", 12'h340, 32'h0);
    expect_rd("mip_meip", 12'h344, 32'h800);
    expect_sig("ret_pc", bus.ret_pc, 32'h100);
    expect_sig("no_take_mie0", {31'd0, bus.trap_take}, 32'h0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = got.pop_front(); checks++;
      if (o !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, o, e.val); end
    end
  endtask

  task automatic test_priority();
    exp_t e; logic [31:0] o;
    bus.irq = '0;
    csr(OP_RS, 12'h304, 32'h80);
    bus.mret = 1'b1; @(negedge clk); bus.mret = 1'b0;
    expect_rd("mstatus_mret", 12'h300, 32'h0000_1888);
    bus.irq = 8'h01; bus.timer_irq = 1'b1;
    #1;
    expect_sig("take_both", {31'd0, bus.trap_take}, 32'h1);
    @(negedge clk);
    expect_rd("mcause_both", 12'h342, 32'h8000_000B);
    bus.mret = 1'b1;
    #1;
    expect_sig("take_during_mret", {31'd0, bus.trap_take}, 32'h0);
    @(negedge clk); bus.mret = 1'b0;
    #1;
    expect_sig("take_again_ext", {31'd0, bus.trap_take}, 32'h1);
    @(negedge clk);
    expect_rd("mcause_again_ext", 12'h342, 32'h8000_000B);
    bus.irq = '0;
    bus.mret = 1'b1; @(negedge clk); bus.mret = 1'b0;
    #1;
    expect_sig("take_timer", {31'd0, bus.trap_take}, 32'h1);
    @(negedge clk);
    expect_rd("mcause_timer", 12'h342, 32'h8000_0007);
    bus.timer_irq = 1'b0;
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = got.pop_front(); checks++;
      if (o !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, o, e.val); end
    end
  endtask

  task automatic test_wfi();
    exp_t e; logic [31:0] o;
    bus.wfi = 1'b1; bus.stall = 1'b1; @(negedge clk); bus.wfi = 1'b0; bus.stall = 1'b0;
    #1;
    expect_sig("wfi_stalled_ignored", {31'd0, bus.wfi_stall}, 32'h0);
    bus.wfi = 1'b1; @(negedge clk); bus.wfi = 1'b0;
    #1;
    expect_sig("wfi_enter", {31'd0, bus.wfi_stall}, 32'h1);
    repeat (3) @(negedge clk);
    #1;
    expect_sig("wfi_hold", {31'd0, bus.wfi_stall}, 32'h1);
    bus.irq = 8'h01;
    #1;
    expect_sig("wfi_no_take", {31'd0, bus.trap_take}, 32'h0);
    expect_sig("wfi_still_set", {31'd0, bus.wfi_stall}, 32'h1);
    @(negedge clk);
    #1;
    expect_sig("wfi_wake", {31'd0, bus.wfi_stall}, 32'h0);
    expect_sig("wfi_wake_no_take", {31'd0, bus.trap_take}, 32'h0);
    bus.irq = '0;
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = got.pop_front(); checks++;
      if (o !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, o, e.val); end
    end
  endtask

  task automatic test_counters();
    exp_t e; logic [31:0] o;
    csr(OP_RW, 12'hB00, 32'hFFFF_FFFF);
    csr(OP_RW, 12'hB80, 32'hFFFF_FFFF);
    expect_rd("mcycle_lo_ones", 12'hB00, 32'hFFFF_FFFF);
    expect_rd("mcycle_hi_ones", 12'hB80, 32'hFFFF_FFFF);
    @(negedge clk);
    expect_rd("mcycle_wrap_lo", 12'hB00, 32'h0);
    expect_rd("mcycle_wrap_hi", 12'hB80, 32'h0);
    @(negedge clk);
    expect_rd("cycle_alias", 12'hC00, 32'h1);
    csr(OP_RW, 12'h340, 32'h5A5A);
    bus.csr_wr = 1'b1; bus.csr_op = OP_RW; bus.csr_addr = 12'h340; bus.csr_wdata = 32'h1234;
    bus.stall = 1'b1;
    @(negedge clk);
    bus.csr_wr = 1'b0; bus.stall = 1'b0;
    expect_rd("stall_no_write", 12'h340, 32'h5A5A);
    bus.retire = 1'b1; bus.stall = 1'b1; @(negedge clk);
    bus.stall = 1'b0; @(negedge clk);
    bus.retire = 1'b0;
    expect_rd("minstret", 12'hB02, 32'h1);
    expect_rd("instreth_alias", 12'hC82, 32'h0);
    csr(OP_RW, 12'h341, 32'h207);
    expect_rd("mepc_align", 12'h341, 32'h204);
    expect_sig("ret_pc_align", bus.ret_pc, 32'h204);
    csr(OP_RW, 12'h305, 32'h0002_0003);
    expect_rd("mtvec_mask", 12'h305, MTVEC_WR_EXP);
    csr(OP_RC, 12'hBC0, 32'h1);
    bus.irq = 8'h01;
    expect_rd("mip_masked", 12'h344, 32'h0);
    expect_rd("irq_en_rc", 12'hBC0, 32'h0000_00FE);
    bus.irq = 8'h05;
    expect_rd("irq_id_masked", 12'hFC0, 32'd2);
    bus.irq = '0;
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = got.pop_front(); checks++;
      if (o !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, o, e.val); end
    end
  endtask

`ifdef CSR_VECTORED_EN
  task automatic test_vectored();
    exp_t e; logic [31:0] o;
    csr(OP_RW, 12'h305, 32'h0001_0001);
    csr(OP_RS, 12'h300, 32'h8);
    bus.pc = 32'h100; bus.irq = 8'h08;
    #1;
    expect_sig("vec_take", {31'd0, bus.trap_take}, 32'h1);
    expect_sig("vec_trap_pc", bus.trap_pc, 32'h0001_004C);
    @(negedge clk);
    expect_rd("vec_mcause", 12'h342, 32'h8000_0013);
    bus.irq = '0;
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = got.pop_front(); checks++;
      if (o !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, o, e.val); end
    end
  endtask
`endif

  task automatic test_async_reset();
    exp_t e; logic [31:0] o;
    bus.irq = '0; bus.timer_irq = 1'b0;
    bus.wfi = 1'b1; @(negedge clk); bus.wfi = 1'b0;
    #1;
    expect_sig("wfi_before_rst", {31'd0, bus.wfi_stall}, 32'h1);
    #2 rst = 1'b0;
    #1;
    expect_sig("wfi_async_rst", {31'd0, bus.wfi_stall}, 32'h0);
    expect_rd("mtvec_async_rst", 12'h305, 32'h0001_0000);
    expect_rd("irq_en_async_rst", 12'hBC0, 32'h0000_00FF);
    expect_rd("mie_async_rst", 12'h304, 32'h0);
    expect_rd("mepc_async_rst", 12'h341, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = got.pop_front(); checks++;
      if (o !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, o, e.val); end
    end
  endtask

  initial begin
    test_reset();
    test_trap();
    test_priority();
    test_wfi();
    test_counters();
`ifdef CSR_VECTORED_EN
    test_vectored();
`endif
    test_async_reset();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
